// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter; one word per valid/ready handshake,
// LSB first, optional odd/even parity, one or two stop bits, exact CLKS_PER_BIT timing.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 tx_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 bit_end;
  assign bit_end  = clk_cnt == CLK_LAST;
  assign tx_ready = state == S_IDLE;
  assign tx_busy  = state != S_IDLE;
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      clk_cnt <= (state == S_IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
      case (state)
        S_IDLE: if (tx_valid) begin
          shreg  <= tx_data;
          par    <= (PARITY == 1) ? ~^tx_data : ^tx_data;
          tx_out <= 1'b0;
          state  <= S_START;
        end
        S_START: if (bit_end) begin
          tx_out <= shreg[0];
          state  <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            bit_idx <= '0;
            tx_out  <= (PARITY != 0) ? par : 1'b1;
            state   <= (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx_out  <= shreg[1];
          end
        end
        S_PAR: if (bit_end) begin
          tx_out <= 1'b1;
          state  <= S_STOP;
        end
        S_STOP: begin
          // registered pulse: raised one cycle early so it lands on the final stop cycle
          if (stop_cnt == STOP_LAST && clk_cnt == DONE_AT) tx_done <= 1'b1;
          if (bit_end) begin
            stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : stop_cnt + 1'b1;
            if (stop_cnt == STOP_LAST) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for 8N1, 7E2 and 7O1 transmitters at 4 clocks per bit.
module tb_uart_tx_param;
  localparam int C = 4;
  localparam int DB [3] = '{8, 7, 7};
  localparam int PB [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 2, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] data_a [3];
  logic valid_a [3];
  logic ready_a [3];
  logic out_a [3];
  logic busy_a [3];
  logic done_a [3];
  logic [15:0] expq [3][$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // expected line level per bit slot, LSB = start bit; slots past the frame read as idle high
  function automatic logic [15:0] frame_bits(input logic [8:0] w, input int i);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < DB[i]; k++) begin
      f[1+k] = w[k];
      ones += int'(w[k]);
    end
    if (PB[i] == 1) f[1+DB[i]] = (ones % 2 == 0);
    if (PB[i] == 2) f[1+DB[i]] = (ones % 2 == 1);
    return f;
  endfunction
  genvar g;
  for (g = 0; g < 3; g++) begin : gi
    localparam int NB = 1 + DB[g] + (PB[g] != 0 ? 1 : 0) + SB[g];
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(DB[g]), .PARITY(PB[g]), .STOP_BITS(SB[g])) dut (
      .tx_clk(clk), .rst_n(rst_n), .tx_data(data_a[g][DB[g]-1:0]), .tx_valid(valid_a[g]),
      .tx_ready(ready_a[g]), .tx_out(out_a[g]), .tx_busy(busy_a[g]), .tx_done(done_a[g]));
    logic [15:0] cur = '1;
    int cyc = 0;
    int errs = 0;
    int dones = 0;
    bit inf = 0;
    always @(negedge clk) begin
      if (!rst_n) begin
        if (inf) check("abort_no_done", dones, 0);
        inf = 0;
        check("reset_outputs", {out_a[g], ready_a[g], busy_a[g], done_a[g]}, 4'b1100);
      end else if (busy_a[g]) begin
        if (!inf) begin
          inf = 1; cyc = 0; errs = 0; dones = 0; cur = '1;
          check("frame_expected", int'(expq[g].size() > 0), 1);
          if (expq[g].size() > 0) cur = expq[g].pop_front();
        end
        if (cyc / C > 15 || out_a[g] !== cur[cyc/C] || ready_a[g]) errs++;
        if (done_a[g]) begin
          dones++;
          if (cyc != NB * C - 1) errs++;
        end
        cyc++;
      end else begin
        if (inf) begin
          check("frame_wave", errs, 0);
          check("frame_len", cyc, NB * C);
          check("frame_done", dones, 1);
        end
        inf = 0;
        check("idle_lines", {out_a[g], ready_a[g], done_a[g]}, 3'b110);
      end
    end
  end
  task automatic send(input int i, input logic [8:0] w, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    data_a[i] = w;
    valid_a[i] = 1'b1;
    while (!ready_a[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", ready_a[i], 1);
    if (ready_a[i]) expq[i].push_back(frame_bits(w, i));
    @(posedge clk);
    #1;
    if (!keep) valid_a[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_a[i] || !ready_a[i]) && n < 200);
    check("idle_wait", busy_a[i], 0);
  endtask
  task automatic wait_done(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a[i] && n < 200);
    check("done_wait", done_a[i], 1);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      data_a[i] = '0;
      valid_a[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    send(0, 9'h0A5, 0); wait_idle(0);
    send(1, 9'h041, 0); wait_idle(1);
    send(2, 9'h041, 0); wait_idle(2);
    send(0, 9'h000, 1);
    repeat (10) @(negedge clk);
    data_a[0] = 9'h03C;
    repeat (20) @(negedge clk);
    data_a[0] = 9'h0FF;
    wait_done(0);
    @(negedge clk);
    check("b2b_idle_ready", ready_a[0], 1);
    expq[0].push_back(frame_bits(9'h0FF, 0));
    @(negedge clk);
    check("b2b_accept", busy_a[0], 1);
    valid_a[0] = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 10; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(i, 9'($urandom_range(0, (1 << DB[i]) - 1)), 0);
        if ($urandom_range(0, 2) == 0) begin
          repeat (3) @(negedge clk);
          data_a[i] = 9'($urandom);
          valid_a[i] = 1'b1;
          @(negedge clk);
          valid_a[i] = 1'b0;
        end
      end
      wait_idle(i);
    end
    send(0, 9'h00F, 0);
    repeat (18) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_out", out_a[0], 1);
    check("async_busy", busy_a[0], 0);
    check("async_ready", ready_a[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 9'h0F0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_out_start", out_a[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 9'h055, 0);
    wait_idle(0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check("queue_empty", expq[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
